// File: rtl/riscv_pkg.sv
// riscv_pkg: shared BIU size encoding, AHB constants and size/alignment helpers
package riscv_pkg;

   typedef enum logic [2:0] {
      BIU_BYTE  = 3'd0,
      BIU_HWORD = 3'd1,
      BIU_WORD  = 3'd2,
      BIU_DWORD = 3'd3
   } biu_size_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   function automatic logic [2:0] biu_size_to_hsize(input biu_size_t s);
      return {1'b0, s[1:0]};
   endfunction

   // DWORD is only legal on a 64-bit bus; otherwise it always faults
   function automatic logic biu_misaligned(input biu_size_t s, input logic [2:0] a, input logic dword_ok);
      return (s[1:0] == 2'd1 && a[0]) ||
             (s[1:0] == 2'd2 && a[1:0] != 2'd0) ||
             (s[1:0] == 2'd3 && (!dword_ok || a != 3'd0));
   endfunction

endpackage

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter: picks one requesting client; round-robin when RISCV_BIU_RR_ARB_EN is defined, else fixed priority
module riscv_biu_arbiter #(
   parameter int NPORT = 2,
   localparam int IW = NPORT > 1 ? $clog2(NPORT) : 1
) (
`ifdef RISCV_BIU_RR_ARB_EN
   input  logic             hclk,
   input  logic             hreset,
   input  logic             adv,
   input  logic [IW-1:0]    adv_idx,
`endif
   input  logic [NPORT-1:0] req,
   output logic [NPORT-1:0] grant,
   output logic [IW-1:0]    idx
);

`ifdef RISCV_BIU_RR_ARB_EN
   logic [IW-1:0] ptr;

   // pointer moves just past the client whose transfer finished
   always_ff @(posedge hclk) begin
      ptr <= hreset ? '0 : adv ? (int'(adv_idx) == NPORT-1 ? '0 : adv_idx + 1'b1) : ptr;
   end
`else
   localparam logic [IW-1:0] ptr = '0;
`endif

   // scan downwards so the requester closest to the pointer is the last (winning) assignment
   always_comb begin
      idx = '0;
      for (int k = NPORT-1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NPORT]) idx = IW'((int'(ptr) + k) % NPORT);
      grant = |req ? NPORT'(1) << idx : '0;
   end

endmodule

// File: rtl/riscv_ahb_mport_biu.sv
// riscv_ahb_mport_biu: merges NPORT client ports onto one AHB master (RISCV_BIU_RR_ARB_EN selects round-robin)
module riscv_ahb_mport_biu
   import riscv_pkg::*;
#(
   parameter int         XLEN          = 32,
   parameter int         NPORT         = 2,
   parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic [NPORT-1:0]   c_req,
   input  logic [NPORT-1:0]   c_we,
   input  logic [NPORT*XLEN-1:0] c_adr,
   input  logic [NPORT*3-1:0] c_size,
   input  logic [NPORT*XLEN-1:0] c_d,
   output logic [XLEN-1:0]    c_q,
   output logic [NPORT-1:0]   c_ack,
   output logic [NPORT-1:0]   c_err,
   output logic               c_misaligned,
   output logic               hbusreq,
   input  logic               hgrant,
   output logic [XLEN-1:0]    haddr,
   output logic [1:0]         htrans,
   output logic [2:0]         hsize,
   output logic [2:0]         hburst,
   output logic [3:0]         hprot,
   output logic               hwrite,
   output logic [XLEN-1:0]    hwdata,
   output logic               hmasterlock,
   input  logic               hready,
   input  logic [XLEN-1:0]    hrdata,
   input  logic [1:0]         hresp
);

   localparam int IW = NPORT > 1 ? $clog2(NPORT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_ERR2} state_t;

   state_t           state;
   logic [IW-1:0]    w, gidx;
   logic [NPORT-1:0] gnt, w_oh, err_r;
   logic             l_we, mis_r, win_mis, ok_done;
   logic [XLEN-1:0]  l_adr, l_d, win_adr;
   biu_size_t        l_size, win_size;

   riscv_biu_arbiter #(.NPORT(NPORT)) u_arb (
`ifdef RISCV_BIU_RR_ARB_EN
      .hclk    (hclk),
      .hreset  (hreset),
      .adv     (((state == S_DATA || state == S_ERR2) && hready) ||
                (state == S_IDLE && |c_req && !(|err_r) && win_mis)),
      .adv_idx ((state == S_IDLE) ? gidx : w),
`endif
      .req     (c_req),
      .grant   (gnt),
      .idx     (gidx)
   );

   assign hburst      = HBURST_SINGLE;
   assign hprot       = HPROT_DEFAULT;
   assign hmasterlock = 1'b0;
   assign w_oh        = NPORT'(1) << w;
   assign ok_done     = state == S_DATA && hready && hresp == HRESP_OKAY;
   assign c_ack       = ok_done ? w_oh : '0;
   assign c_q         = ok_done ? hrdata : '0;
   assign c_err       = err_r;
   assign c_misaligned = mis_r;

   // view of the current arbitration winner's request
   always_comb begin
      win_adr  = c_adr[int'(gidx)*XLEN +: XLEN];
      win_size = biu_size_t'(c_size[int'(gidx)*3 +: 3]);
      win_mis  = biu_misaligned(win_size, win_adr[2:0], XLEN == 64);
   end

   // transfer sequencer; error pulses are registered so the client sees them one cycle later
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state   <= S_IDLE;
         hbusreq <= 1'b0;
         htrans  <= HTRANS_IDLE;
         haddr   <= '0;
         hsize   <= '0;
         hwrite  <= 1'b0;
         hwdata  <= '0;
         err_r   <= '0;
         mis_r   <= 1'b0;
         w       <= '0;
         l_we    <= 1'b0;
         l_adr   <= '0;
         l_size  <= BIU_BYTE;
         l_d     <= '0;
      end else begin
         err_r <= '0;
         mis_r <= 1'b0;
         case (state)
            S_IDLE:
               if (|c_req && !(|err_r)) begin
                  w      <= gidx;
                  l_we   <= c_we[gidx];
                  l_adr  <= win_adr;
                  l_size <= win_size;
                  l_d    <= c_d[int'(gidx)*XLEN +: XLEN];
                  if (win_mis) begin
                     err_r <= gnt;
                     mis_r <= 1'b1;
                  end else begin
                     state   <= S_REQ;
                     hbusreq <= 1'b1;
                  end
               end
            S_REQ:
               if (!c_req[w]) begin
                  state   <= S_IDLE;
                  hbusreq <= 1'b0;
               end else if (hgrant && hready) begin
                  state  <= S_ADDR;
                  htrans <= HTRANS_NONSEQ;
                  haddr  <= l_adr;
                  hsize  <= biu_size_to_hsize(l_size);
                  hwrite <= l_we;
               end
            S_ADDR:
               if (hready) begin
                  htrans <= HTRANS_IDLE;
                  if (hgrant) begin
                     state   <= S_DATA;
                     hbusreq <= 1'b0;
                     hwdata  <= l_d;
                  end else
                     state <= S_REQ;
               end
            S_DATA:
               if (hready) begin
                  state <= S_IDLE;
                  if (hresp != HRESP_OKAY) err_r <= w_oh;
               end else if (hresp == HRESP_ERROR)
                  state <= S_ERR2;
               else if (hresp == HRESP_RETRY || hresp == HRESP_SPLIT) begin
                  state   <= S_REQ;
                  hbusreq <= 1'b1;
               end
            S_ERR2:
               if (hready) begin
                  state <= S_IDLE;
                  err_r <= w_oh;
               end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_ahb_mport_biu.sv
// tb_riscv_ahb_mport_biu: vector table, random traffic vs byte-level memory model, and hand-built bus corner cases
module tb_riscv_ahb_mport_biu;

   localparam int XLEN  = 32;
   localparam int NPORT = 3;

   logic              hclk = 1'b0;
   logic              hreset;
   logic [NPORT-1:0]  c_req, c_we, c_ack, c_err;
   logic [NPORT*XLEN-1:0] c_adr, c_d;
   logic [NPORT*3-1:0] c_size;
   logic [XLEN-1:0]   c_q, haddr, hwdata, hrdata;
   logic              c_misaligned, hbusreq, hgrant, hwrite, hmasterlock, hready;
   logic [1:0]        htrans, hresp;
   logic [2:0]        hsize, hburst;
   logic [3:0]        hprot;

   riscv_ahb_mport_biu #(.XLEN(XLEN), .NPORT(NPORT)) dut (
      .hclk(hclk), .hreset(hreset), .c_req(c_req), .c_we(c_we), .c_adr(c_adr),
      .c_size(c_size), .c_d(c_d), .c_q(c_q), .c_ack(c_ack), .c_err(c_err),
      .c_misaligned(c_misaligned), .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr),
      .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite),
      .hwdata(hwdata), .hmasterlock(hmasterlock), .hready(hready), .hrdata(hrdata), .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      return 8'((a * 7 + 53) & 255);
   endfunction

   function automatic logic [31:0] init_word(input int i);
      return {init_byte(4*i+3), init_byte(4*i+2), init_byte(4*i+1), init_byte(4*i)};
   endfunction

   function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
      return sz == 3'd0 ? 32'hFF << (8*a) : sz == 3'd1 ? 32'hFFFF << (16*a[1]) : 32'hFFFF_FFFF;
   endfunction

   // AHB slave: 1 KiB word memory, zero wait unless the bench overrides hready/hresp
   logic [31:0] smem [0:255];
   logic        seeded = 1'b0, dp_valid = 1'b0, dp_write = 1'b0, last_write = 1'b0;
   logic [31:0] dp_addr = '0, last_addr = '0;
   logic [2:0]  dp_size = '0, last_size = '0;

   always @(posedge hclk) begin
      if (hreset) begin
         dp_valid <= 1'b0;
         if (!seeded) begin
            for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
            seeded <= 1'b1;
         end
      end else if (hready) begin
         if (dp_valid && dp_write && hresp == 2'b00)
            smem[dp_addr[9:2]] <= (smem[dp_addr[9:2]] & ~lane_mask(dp_size, dp_addr[1:0])) |
                                  (hwdata & lane_mask(dp_size, dp_addr[1:0]));
         dp_valid <= hgrant && htrans == 2'b10;
         if (hgrant && htrans == 2'b10) begin
            dp_addr <= haddr; dp_size <= hsize; dp_write <= hwrite;
            last_addr <= haddr; last_size <= hsize; last_write <= hwrite;
         end
      end
   end

   assign hrdata = dp_valid ? smem[dp_addr[9:2]] : 32'h0;

   // reference model: byte-addressed memory and the alignment rule stated as arithmetic
   logic [7:0] mb [0:1023];

   function automatic bit model_mis(input logic [2:0] sz, input logic [31:0] a);
      int n = 1 << sz[1:0];
      return sz[1:0] == 2'd3 || (int'(a[9:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      int b = int'(a[9:0]) & ~3;
      return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      for (int i = 0; i < (1 << sz[1:0]); i++) begin
         int b = int'(a[9:0]) + i;
         mb[b] = d[8*(b%4) +: 8];
      end
   endtask

   task automatic check_reset(input string t);
      check({t, ".hbusreq"}, hbusreq, 0);
      check({t, ".htrans"}, htrans, 0);
      check({t, ".haddr"}, haddr, 0);
      check({t, ".hsize"}, hsize, 0);
      check({t, ".hwrite"}, hwrite, 0);
      check({t, ".hwdata"}, hwdata, 0);
      check({t, ".c_ack"}, c_ack, 0);
      check({t, ".c_err"}, c_err, 0);
      check({t, ".c_mis"}, c_misaligned, 0);
      check({t, ".c_q"}, c_q, 0);
   endtask

   task automatic drive(input int p, input bit we, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      c_we[p] = we;
      c_adr[p*XLEN +: XLEN] = a;
      c_size[p*3 +: 3] = sz;
      c_d[p*XLEN +: XLEN] = d;
   endtask

   task automatic run_and_check(input string t, input int p, input bit we, input logic [31:0] a,
                                input logic [2:0] sz, input logic [31:0] d, input bit exp_mis);
      logic [NPORT-1:0] ackv = '0, errv = '0;
      logic misf = 1'b0;
      logic [31:0] q = '0, expq;
      int lat = 0, nsn = 0;
      bit bus = 1'b0;
      expq = model_word(a);
      drive(p, we, a, sz, d);
      c_req[p] = 1'b1;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge hclk);
         if (htrans == 2'b10 && nsn == 0) nsn = n;
         if (hbusreq || htrans != 2'b00) bus = 1'b1;
         if (c_ack != 0 || c_err != 0) begin
            ackv = c_ack; errv = c_err; misf = c_misaligned; q = c_q; lat = n;
         end
      end
      c_req[p] = 1'b0;
      check({t, ".done"}, lat != 0, 1);
      check({t, ".ack"}, ackv, exp_mis ? 0 : 1 << p);
      check({t, ".err"}, errv, exp_mis ? 1 << p : 0);
      check({t, ".mis"}, misf, exp_mis);
      if (exp_mis) begin
         check({t, ".lat"}, lat, 1);
         check({t, ".bus"}, bus, 0);
      end else begin
         check({t, ".lat"}, lat, 3);
         check({t, ".nonseq"}, nsn, 2);
         check({t, ".haddr"}, last_addr, a);
         check({t, ".hsize"}, last_size, {1'b0, sz[1:0]});
         check({t, ".hwrite"}, last_write, we);
         if (we) model_write(a, sz, d);
         else check({t, ".q"}, q, expq);
      end
      @(negedge hclk);
   endtask

   typedef struct {
      int          p;
      bit          we;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] d;
      bit          mis;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int order [6];
      int nack, nns, acks;
      bit bad;
      for (int a = 0; a < 1024; a++) mb[a] = init_byte(a);
      tbl = '{
         '{0, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 1'b0},
         '{0, 1'b0, 32'h100, 3'd2, 32'h0,        1'b0},
         '{1, 1'b1, 32'h201, 3'd0, 32'h0000AA00, 1'b0},
         '{1, 1'b0, 32'h200, 3'd2, 32'h0,        1'b0},
         '{0, 1'b0, 32'h102, 3'd2, 32'h0,        1'b1},
         '{2, 1'b0, 32'h101, 3'd1, 32'h0,        1'b1},
         '{2, 1'b1, 32'h102, 3'd1, 32'h12340000, 1'b0},
         '{2, 1'b0, 32'h100, 3'd1, 32'h0,        1'b0},
         '{1, 1'b0, 32'h100, 3'd3, 32'h0,        1'b1},
         '{1, 1'b0, 32'h203, 3'd0, 32'h0,        1'b0},
         '{0, 1'b1, 32'h104, 3'd2, 32'hCAFEF00D, 1'b0},
         '{1, 1'b0, 32'h104, 3'd2, 32'h0,        1'b0}
      };
      hreset = 1'b1; c_req = '0; c_we = '0; c_adr = '0; c_size = '0; c_d = '0;
      hgrant = 1'b1; hready = 1'b1; hresp = 2'b00;
      repeat (3) @(negedge hclk);
      check_reset("reset");
      check("hburst", hburst, 0);
      check("hprot", hprot, 4'b0011);
      check("hmasterlock", hmasterlock, 0);
      hreset = 1'b0;
      @(negedge hclk);

      for (int i = 0; i < 12; i++)
         run_and_check($sformatf("vec%0d", i), tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].sz, tbl[i].d, tbl[i].mis);

      // two-cycle ERROR response on a write from port 1
      drive(1, 1'b1, 32'h204, 3'd1, 32'h00005A5A);
      c_req[1] = 1'b1;
      @(negedge hclk);
      check("err.hbusreq", hbusreq, 1);
      @(negedge hclk);
      check("err.htrans_a", htrans, 2'b10);
      check("err.haddr", haddr, 32'h204);
      check("err.hwrite", hwrite, 1);
      @(posedge hclk); #1;
      hresp = 2'b01; hready = 1'b0;
      @(negedge hclk);
      check("err.hwdata", hwdata, 32'h00005A5A);
      check("err.htrans_d", htrans, 0);
      check("err.ack1", c_ack, 0);
      check("err.err1", c_err, 0);
      @(posedge hclk); #1;
      hready = 1'b1;
      @(negedge hclk);
      check("err.htrans_e", htrans, 0);
      check("err.err2", c_err, 0);
      check("err.ack2", c_ack, 0);
      @(posedge hclk); #1;
      hresp = 2'b00;
      @(negedge hclk);
      check("err.err3", c_err, 3'b010);
      check("err.mis3", c_misaligned, 0);
      check("err.ack3", c_ack, 0);
      c_req[1] = 1'b0;
      @(negedge hclk);
      check("err.err4", c_err, 0);

      // grant lost in the address phase, re-granted four cycles later
      drive(0, 1'b0, 32'h104, 3'd2, 32'h0);
      c_req[0] = 1'b1;
      nns = 0; nack = 0; bad = 1'b0;
      repeat (2) begin
         @(negedge hclk);
         if (htrans == 2'b10) nns++;
      end
      hgrant = 1'b0;
      repeat (4) begin
         @(negedge hclk);
         if (htrans == 2'b10) nns++;
         if (c_ack != 0) nack++;
      end
      check("regrant.hbusreq", hbusreq, 1);
      hgrant = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge hclk);
         if (htrans == 2'b10) nns++;
         if (c_ack != 0) begin
            nack++;
            if (c_ack != 3'b001 || c_q != model_word(32'h104)) bad = 1'b1;
            c_req[0] = 1'b0;
         end
      end
      c_req[0] = 1'b0;
      check("regrant.acks", nack, 1);
      check("regrant.nonseq", nns, 2);
      check("regrant.data", bad, 0);

      // request withdrawn while still waiting for the bus
      hgrant = 1'b0;
      drive(2, 1'b0, 32'h200, 3'd2, 32'h0);
      c_req[2] = 1'b1;
      repeat (3) @(negedge hclk);
      check("drop.hbusreq", hbusreq, 1);
      c_req[2] = 1'b0;
      bad = 1'b0;
      repeat (2) @(negedge hclk);
      hgrant = 1'b1;
      repeat (3) begin
         @(negedge hclk);
         if (hbusreq || htrans != 0 || c_ack != 0 || c_err != 0) bad = 1'b1;
      end
      check("drop.quiet", bad, 0);

      // reset while the slave stalls the data phase
      drive(1, 1'b0, 32'h200, 3'd2, 32'h0);
      c_req[1] = 1'b1;
      repeat (2) @(negedge hclk);
      @(posedge hclk); #1;
      hready = 1'b0;
      @(negedge hclk);
      check("rstdata.ack", c_ack, 0);
      hreset = 1'b1;
      c_req = '0;
      @(negedge hclk);
      check_reset("rstdata");
      hreset = 1'b0;
      hready = 1'b1;
      @(negedge hclk);
      run_and_check("after_rst", 1, 1'b0, 32'h200, 3'd2, 32'h0, 1'b0);

      // all three ports request continuously from a freshly reset arbiter
      hreset = 1'b1;
      repeat (2) @(negedge hclk);
      hreset = 1'b0;
      drive(0, 1'b0, 32'h100, 3'd2, 32'h0);
      drive(1, 1'b0, 32'h104, 3'd2, 32'h0);
      drive(2, 1'b0, 32'h200, 3'd2, 32'h0);
      c_req = 3'b111;
      acks = 0; bad = 1'b0;
      for (int n = 0; n < 80 && acks < 6; n++) begin
         @(negedge hclk);
         if (c_ack != 0) begin
            if (!$onehot(c_ack)) bad = 1'b1;
            for (int k = 0; k < NPORT; k++)
               if (c_ack[k]) begin
                  order[acks] = k;
                  if (c_q != model_word(c_adr[k*XLEN +: XLEN])) bad = 1'b1;
               end
            acks++;
         end
      end
      c_req = '0;
      check("arb.count", acks, 6);
      check("arb.data", bad, 0);
      for (int k = 0; k < 6; k++)
`ifdef RISCV_BIU_RR_ARB_EN
         check($sformatf("arb.order%0d", k), order[k], k % 3);
`else
         check($sformatf("arb.order%0d", k), order[k], 0);
`endif
      repeat (2) @(negedge hclk);

      // random traffic checked against the byte memory model
      for (int i = 0; i < 40; i++) begin
         int p = int'($urandom_range(0, NPORT-1));
         bit we = 1'($urandom_range(0, 1));
         logic [2:0] sz = 3'($urandom_range(0, 3));
         logic [31:0] a = 32'($urandom_range(0, 1023));
         logic [31:0] d = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz[1:0]) - 1);
         run_and_check($sformatf("rnd%0d", i), p, we, a, sz, d, model_mis(sz, a));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
